uart_tx_fifo_param: RTL

Parametrised synchronous FIFO that buffers bytes (or wider words) between the bus-side register interface and the UART TX shifter. It generalises the 32×8 TX FIFO: configurable width and depth, usage of all DEPTH entries, occupancy count, programmable almost-full/almost-empty thresholds, a registered read-valid strobe, synchronous flush and sticky overflow/underflow error flags.

---
 rtl/uart_tx_fifo_param_if.sv | 31 +++
 rtl/uart_tx_fifo_param.sv | 101 ++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_param_if.sv
// Handshake bundle between the bus-side writer and the UART TX shifter reading the FIFO.
interface uart_tx_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              we;
  logic [DATA_W-1:0] data_in;
  logic              re;
  logic [DATA_W-1:0] data_o;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CW-1:0]     count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, we, data_in, re,
    input  data_o, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, we, data_in, re,
    output data_o, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/uart_tx_fifo_param.sv
// Parametrised TX FIFO: full-depth storage, occupancy count, thresholds, registered read port,
// synchronous flush and sticky overflow/underflow flags.
module uart_tx_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  uart_tx_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              full_s, empty_s, wr_ok_s, rd_ok_s;

  assign full_s  = (count_q == DEPTH_C);
  assign empty_s = (count_q == {CW{1'b0}});
  // Flush swallows any request in its cycle, so it is folded into the accept terms.
  assign rd_ok_s = bus.re && !empty_s && !bus.flush;
  assign wr_ok_s = bus.we && (!full_s || rd_ok_s) && !bus.flush;

  // Next-state computation for pointers, count, read port and error flags.
  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    data_d     = data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (bus.flush) begin
      wp_d       = {AW{1'b0}};
      rp_d       = {AW{1'b0}};
      count_d    = {CW{1'b0}};
      rd_valid_d = 1'b0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
    end else begin
      wp_d       = wr_ok_s ? wp_q + AW'(1) : wp_q;
      rp_d       = rd_ok_s ? rp_q + AW'(1) : rp_q;
      data_d     = rd_ok_s ? mem_q[rp_q] : data_q;
      rd_valid_d = rd_ok_s;
      case ({wr_ok_s, rd_ok_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (bus.we & full_s & ~rd_ok_s);
      unf_d = unf_q | (bus.re & empty_s);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp_q       <= {AW{1'b0}};
      rp_q       <= {AW{1'b0}};
      count_q    <= {CW{1'b0}};
      data_q     <= {DATA_W{1'b0}};
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      data_q     <= data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage array is deliberately not reset; unwritten slots are never read out.
  always_ff @(posedge clk_i) begin
    if (wr_ok_s && !rst_i) begin
      mem_q[wp_q] <= bus.data_in;
    end
  end

  assign bus.data_o       = data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.count        = count_q;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule
